mac_frame: RTL and testbench
============================

# mac_frame

Parametrised, pipelined multiply-accumulate engine that sums LEN scaled products per frame and hands each frame result downstream. It is the next generation of the 8-bit single-stage `mac`, adding configurable widths, a valid/ready stream on both sides, frame counting, a synchronous clear, and selectable wrap or saturate accumulation. It sits between a sample source and a consumer of frame results such as a filter tap bank or a dot-product reader.

## Interface
- XW, 8: operand width (unsigned x1, x2)
- SHIFT, 6: right shift applied to the full product
- MW, 2*XW-SHIFT: product width after shift (derived; do not override)
- AW, 10: accumulator width
- LEN, 16: products per frame (LEN >= 2)
- SAT, 0: 0 = wrap modulo 2^AW, 1 = saturate at 2^AW-1

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- clear  in  1  synchronous abort of the current frame
- in_valid  in  1  operand beat valid
- in_ready  out  1  engine accepts a beat
- x1  in  XW  operand 1
- x2  in  XW  operand 2
- m  out  MW  registered product of the last accepted beat
- y  out  AW  running accumulator
- count  out  $clog2(LEN)  beats accepted in the current frame
- out_valid  out  1  frame result valid
- out_ready  in  1  consumer takes the result
- out_y  out  AW  frame sum
- out_ovf  out  1  overflow occurred in this frame

## Operation
- A beat is accepted when in_valid && in_ready.
- Stage 1: m <= (x1*x2) >> SHIFT, computed at full 2*XW width and then truncated to MW. m updates only on an accepted beat; otherwise m_vld=0.
- Stage 2: when m_vld=1, y <= y + m at AW+1 bits.
  - On carry-out, SAT=0 keeps the low AW bits; SAT=1 loads 2^AW-1.
  - In both modes, a carry-out sets the sticky ovf flag.
- The FSM lives in mac_pkg as mac_state_t {ACC, FLUSH, HOLD}.
  - ACC: in_ready=1. Each accepted beat increments count. The beat accepted with count==LEN-1 moves the FSM to FLUSH and wraps count to 0.
  - FLUSH: in_ready=0 for exactly one cycle. The last product is added; at the same edge out_y and out_ovf are loaded with the final sum and flag, y and ovf are cleared to 0, out_valid is set to 1, and the FSM moves to HOLD.
  - HOLD: in_ready=0. out_y and out_ovf hold stable while out_valid=1. When out_valid && out_ready, out_valid returns to 0 and the FSM moves to ACC.
- clear (sync, sampled at the clock edge):
  - Forces state=ACC and zeroes count, y, m, m_vld, ovf and out_valid.
  - A beat presented in the same cycle is dropped.
  - clear overrides every other event.
- reset (async, active-low): same zeroing as clear, plus out_y=0 and out_ovf=0. in_ready reads 1 during and after reset, because state is ACC.
- Idle cycles (in_valid=0) change neither count nor y.

## Timing
- m is valid 1 cycle after acceptance; y reflects that beat 2 cycles after acceptance.
- Last beat accepted at edge E: FLUSH during cycle E..E+1, out_valid=1 from E+1.
- Minimum frame period: LEN+2 cycles, with out_ready tied high.
- Backpressure: out_valid may stay high indefinitely; in_ready stays 0 until the cycle after the output handshake.
- Reset mid-frame or mid-HOLD: all outputs reach their reset values asynchronously; no partial result is emitted.

## Structure
- mac_pkg holds:
  - mac_state_t
  - default constants MAC_XW=8, MAC_SHIFT=6, MAC_AW=10
  - the function mac_mw(xw, shift) returning 2*xw-shift
- One sub-module, mac_mul_stage: the stage-1 multiply/shift register with m and m_vld. The top level holds the FSM, the accumulator, saturation logic and the output register.

## Test plan
Use XW=8, SHIFT=6, AW=10, LEN=4.
1. Reset: assert reset=0 for 3 cycles -> m=0, y=0, count=0, out_valid=0, out_y=0, out_ovf=0, in_ready=1.
2. Normal frame: beats (10,13), (64,64), (128,128), (1,1) with out_ready=1 -> m reads 2, 64, 256, 0 one cycle after each beat; out_y=322 and out_ovf=0 at last acceptance +1; in_ready=0 for exactly 2 cycles.
3. Overflow: 4 beats of (200,100), giving m=312 each -> SAT=0: out_y=224, out_ovf=1; SAT=1: out_y=1023, out_ovf=1; the next frame starts with y=0 and ovf=0.
4. Backpressure and bubbles:
   - Interleave in_valid=0 cycles between beats -> count and y unchanged on bubbles, same out_y=322.
   - Hold out_ready=0 for 5 cycles -> out_valid=1, out_y stable, in_ready=0 throughout.
   - Raise out_ready=1 -> out_valid=0 and in_ready=1 on the next cycle.
5. clear mid-frame: after 2 beats, assert clear for 1 cycle while in_valid=1 -> count=0, y=0, the concurrent beat is dropped, and a following full frame gives out_y=322.
6. Async reset: drop reset between clock edges while in HOLD -> out_valid=0 and out_y=0 immediately; after release, a normal frame completes correctly.

Source files
------------

// File: rtl/mac_frame_pkg.sv
// Shared types and defaults for the mac_frame multiply-accumulate engine.
package mac_pkg;

  typedef enum logic [1:0] {ACC, FLUSH, HOLD} mac_state_t;

  localparam int MAC_XW    = 8;
  localparam int MAC_SHIFT = 6;
  localparam int MAC_AW    = 10;

  function automatic int mac_mw(input int xw, input int shift);
    return 2 * xw - shift;
  endfunction

endpackage

// File: rtl/mac_frame_if.sv
// Operand input stream and frame-result output stream of mac_frame.
interface mac_frame_if #(
  parameter int XW = 8,
  parameter int AW = 10
);
  logic          in_valid;
  logic          in_ready;
  logic [XW-1:0] x1;
  logic [XW-1:0] x2;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_y;
  logic          out_ovf;

  modport master (
    output in_valid, x1, x2, out_ready,
    input  in_ready, out_valid, out_y, out_ovf
  );

  modport slave (
    input  in_valid, x1, x2, out_ready,
    output in_ready, out_valid, out_y, out_ovf
  );
endinterface

// File: rtl/mac_frame_mul_stage.sv
// Stage 1: registered scaled product of each accepted operand beat.
module mac_mul_stage #(
  parameter int XW    = 8,
  parameter int SHIFT = 6,
  parameter int MW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          accept,
  input  logic [XW-1:0] x1,
  input  logic [XW-1:0] x2,
  output logic [MW-1:0] m,
  output logic          m_vld
);

  logic [2*XW-1:0] prod;
  logic [MW-1:0]   prod_sh;

  always_comb begin
    prod    = {{XW{1'b0}}, x1} * {{XW{1'b0}}, x2};
    prod_sh = MW'(prod >> SHIFT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m     <= '0;
      m_vld <= 1'b0;
    end else if (clear) begin
      m     <= '0;
      m_vld <= 1'b0;
    end else begin
      m_vld <= accept;
      if (accept) m <= prod_sh;
    end
  end

endmodule

// File: rtl/mac_frame.sv
// Pipelined frame MAC: sums LEN scaled products, then hands the sum downstream.
module mac_frame
  import mac_pkg::*;
#(
  parameter int XW    = MAC_XW,
  parameter int SHIFT = MAC_SHIFT,
  parameter int AW    = MAC_AW,
  parameter int LEN   = 16,
  parameter int SAT   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  mac_frame_if.slave             bus,
  output logic [mac_mw(XW, SHIFT)-1:0] m,
  output logic [AW-1:0]          y,
  output logic [$clog2(LEN)-1:0] count
);

  localparam int MW = mac_mw(XW, SHIFT);
  localparam int CW = $clog2(LEN);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  mac_state_t    state;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [AW-1:0] out_y_q;
  logic          out_ovf_q;
  logic          ovf;
  logic          m_vld;
  logic          accept;
  logic [AW:0]   sum;
  logic          carry;
  logic [AW-1:0] acc_next;

  assign accept        = bus.in_valid && in_ready_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_ovf   = out_ovf_q;

  mac_mul_stage #(
    .XW   (XW),
    .SHIFT(SHIFT),
    .MW   (MW)
  ) u_mul (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .accept(accept),
    .x1    (bus.x1),
    .x2    (bus.x2),
    .m     (m),
    .m_vld (m_vld)
  );

  always_comb begin
    sum      = {1'b0, y} + (AW+1)'(m);
    carry    = sum[AW];
    acc_next = (carry && SAT != 0) ? '1 : sum[AW-1:0];
  end

  // FLUSH always sees m_vld=1: it is entered only on the edge that accepted the last beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ACC;
      in_ready_q  <= 1'b1;
      count       <= '0;
      y           <= '0;
      ovf         <= 1'b0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_ovf_q   <= 1'b0;
    end else if (clear) begin
      state       <= ACC;
      in_ready_q  <= 1'b1;
      count       <= '0;
      y           <= '0;
      ovf         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            if (count == LAST) begin
              count      <= '0;
              state      <= FLUSH;
              in_ready_q <= 1'b0;
            end else begin
              count <= count + 1'b1;
            end
          end
          if (m_vld) begin
            y   <= acc_next;
            ovf <= ovf | carry;
          end
        end
        FLUSH: begin
          out_y_q     <= acc_next;
          out_ovf_q   <= ovf | carry;
          y           <= '0;
          ovf         <= 1'b0;
          out_valid_q <= 1'b1;
          state       <= HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= ACC;
          end
        end
        default: begin
          state      <= ACC;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_frame.sv
// Directed test of mac_frame (XW=8, SHIFT=6, AW=10, LEN=4), wrap and saturate instances side by side.
module tb_mac_frame;

  logic clk;
  logic reset;
  logic clear;

  mac_frame_if #(.XW(8), .AW(10)) bus0 ();
  mac_frame_if #(.XW(8), .AW(10)) bus1 ();

  logic [9:0] m0, m1, y0, y1;
  logic [1:0] c0, c1;

  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.x1        = bus0.x1;
  assign bus1.x2        = bus0.x2;
  assign bus1.out_ready = bus0.out_ready;

  mac_frame #(.XW(8), .SHIFT(6), .AW(10), .LEN(4), .SAT(0)) dut (
    .clk(clk), .reset(reset), .clear(clear), .bus(bus0), .m(m0), .y(y0), .count(c0)
  );

  mac_frame #(.XW(8), .SHIFT(6), .AW(10), .LEN(4), .SAT(1)) dut_sat (
    .clk(clk), .reset(reset), .clear(clear), .bus(bus1), .m(m1), .y(y1), .count(c1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int nx1 [4] = '{10, 64, 128, 1};
  int nx2 [4] = '{13, 64, 128, 1};
  int nm  [4] = '{2, 64, 256, 0};
  int ps  [3] = '{2, 66, 322};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic send(input string tag, input int a, input int b);
    check({tag, ".in_ready"}, 32'(bus0.in_ready), 1);
    bus0.in_valid = 1'b1;
    bus0.x1       = 8'(a);
    bus0.x2       = 8'(b);
    @(negedge clk);
    bus0.in_valid = 1'b0;
  endtask

  task automatic beats(input string tag, input bit bub);
    for (int i = 0; i < 4; i++) begin
      send(tag, nx1[i], nx2[i]);
      check({tag, ".m"}, 32'(m0), nm[i]);
      check({tag, ".count"}, 32'(c0), (i + 1) % 4);
      if (bub && i < 3) begin
        repeat (2) @(negedge clk);
        check({tag, ".bub_y"}, 32'(y0), ps[i]);
        check({tag, ".bub_count"}, 32'(c0), i + 1);
      end
    end
    check({tag, ".flush_ready"}, 32'(bus0.in_ready), 0);
    check({tag, ".flush_y"}, 32'(y0), 322);
  endtask

  task automatic drain(input string tag, input int hold);
    int t;
    bus0.out_ready = (hold == 0);
    t = 0;
    while (!bus0.out_valid && t < 8) begin
      @(negedge clk);
      t++;
    end
    check({tag, ".latency"}, t, 1);
    check({tag, ".out_y"}, 32'(bus0.out_y), 322);
    check({tag, ".out_ovf"}, 32'(bus0.out_ovf), 0);
    check({tag, ".sat_out_y"}, 32'(bus1.out_y), 322);
    check({tag, ".hold_ready"}, 32'(bus0.in_ready), 0);
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      check({tag, ".bp_valid"}, 32'(bus0.out_valid), 1);
      check({tag, ".bp_out_y"}, 32'(bus0.out_y), 322);
      check({tag, ".bp_ready"}, 32'(bus0.in_ready), 0);
    end
    bus0.out_ready = 1'b1;
    @(negedge clk);
    check({tag, ".done_valid"}, 32'(bus0.out_valid), 0);
    check({tag, ".done_ready"}, 32'(bus0.in_ready), 1);
    check({tag, ".done_y"}, 32'(y0), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b0;
    clear          = 1'b0;
    bus0.in_valid  = 1'b0;
    bus0.x1        = '0;
    bus0.x2        = '0;
    bus0.out_ready = 1'b1;

    // 1. reset
    repeat (3) @(negedge clk);
    check("rst.m", 32'(m0), 0);
    check("rst.y", 32'(y0), 0);
    check("rst.count", 32'(c0), 0);
    check("rst.out_valid", 32'(bus0.out_valid), 0);
    check("rst.out_y", 32'(bus0.out_y), 0);
    check("rst.out_ovf", 32'(bus0.out_ovf), 0);
    check("rst.in_ready", 32'(bus0.in_ready), 1);
    reset = 1'b1;
    @(negedge clk);

    // 2. normal frame
    beats("norm", 1'b0);
    drain("norm", 0);

    // 3. overflow: 4 x 312 = 1248 -> wrap 224, saturate 1023
    for (int i = 0; i < 4; i++) begin
      send("ovf", 200, 100);
      check("ovf.m", 32'(m0), 312);
    end
    @(negedge clk);
    check("ovf.out_valid", 32'(bus0.out_valid), 1);
    check("ovf.out_y", 32'(bus0.out_y), 224);
    check("ovf.out_ovf", 32'(bus0.out_ovf), 1);
    check("ovf.sat_out_y", 32'(bus1.out_y), 1023);
    check("ovf.sat_out_ovf", 32'(bus1.out_ovf), 1);
    @(negedge clk);
    check("ovf.in_ready", 32'(bus0.in_ready), 1);
    check("ovf.y", 32'(y0), 0);
    check("ovf.sat_y", 32'(y1), 0);
    beats("post_ovf", 1'b0);
    drain("post_ovf", 0);
    check("post_ovf.sat_ovf", 32'(bus1.out_ovf), 0);

    // 4. bubbles and backpressure
    beats("bub", 1'b1);
    drain("bp", 5);

    // 5. clear mid-frame with a concurrent beat
    send("clr", 10, 13);
    send("clr", 64, 64);
    clear         = 1'b1;
    bus0.in_valid = 1'b1;
    bus0.x1       = 8'd128;
    bus0.x2       = 8'd128;
    @(negedge clk);
    clear         = 1'b0;
    bus0.in_valid = 1'b0;
    check("clr.count", 32'(c0), 0);
    check("clr.y", 32'(y0), 0);
    check("clr.m", 32'(m0), 0);
    check("clr.in_ready", 32'(bus0.in_ready), 1);
    @(negedge clk);
    check("clr.y_after", 32'(y0), 0);
    beats("post_clr", 1'b0);
    drain("post_clr", 0);

    // 6. async reset while holding a result
    beats("arst", 1'b0);
    bus0.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("arst.hold_valid", 32'(bus0.out_valid), 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst.out_valid", 32'(bus0.out_valid), 0);
    check("arst.out_y", 32'(bus0.out_y), 0);
    check("arst.in_ready", 32'(bus0.in_ready), 1);
    check("arst.sat_out_y", 32'(bus1.out_y), 0);
    @(negedge clk);
    reset          = 1'b1;
    bus0.out_ready = 1'b1;
    @(negedge clk);
    check("arst.out_valid_after", 32'(bus0.out_valid), 0);
    beats("post_arst", 1'b0);
    drain("post_arst", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
